// File: rtl/ram_pkg.sv
// Shared definitions for the block-RAM bus master: default widths, command codes, FSM states.
// Pure declarations; no timing or flow-control behaviour lives here.
package ram_pkg;

  localparam int RAM_ADDR_WIDTH = 11;
  localparam int RAM_DATA_WIDTH = 16;
  localparam int RAM_LEN_WIDTH  = 8;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_RD_FIRST  = 3'd2,
    ST_RD_STREAM = 3'd3,
    ST_RD_LAST   = 3'd4
  } state_e;

endpackage

// File: rtl/ram_burst_counter.sv
// Burst address register and remaining-words counter; flags update one cycle after load/step.
// No flow control of its own: the owning FSM decides when to load or step.
module ram_burst_counter
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = RAM_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  addr_step_i,
  input  logic                  rem_step_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o,
  output logic                  next_last_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;

  // Address wraps naturally at the top of the RAM; remaining saturates at zero.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_i) begin
      addr_d = addr_i;
      rem_d  = len_i;
    end else begin
      if (addr_step_i) addr_d = addr_q + ADDR_WIDTH'(1);
      if (rem_step_i && (rem_q != '0)) rem_d = rem_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr_o      = addr_q;
  assign last_o      = (rem_q == '0);
  assign next_last_o = (rem_q == LEN_WIDTH'(1));

endmodule

// File: rtl/ram_bus_master.sv
// Block-RAM bus initiator: single/burst writes stored on the handshake edge, reads pipelined with word i on rd_data 3+i cycles after accept.
// Commands accepted only in IDLE; write words stall via wr_valid; read data has no backpressure.
module ram_bus_master
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = RAM_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] address_bus,
  inout  wire  [DATA_WIDTH-1:0] data_bus,
  output logic                  enable,
  output logic                  write,
  output logic                  read
);

  state_e state_q, state_d;

  logic                  cnt_load;
  logic                  cnt_addr_step;
  logic                  cnt_rem_step;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic                  cnt_last;
  logic                  cnt_next_last;

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  capture;

  ram_burst_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_counter (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (cnt_load),
    .addr_i      (cmd_addr),
    .len_i       (cmd_len),
    .addr_step_i (cnt_addr_step),
    .rem_step_i  (cnt_rem_step),
    .addr_o      (cnt_addr),
    .last_o      (cnt_last),
    .next_last_o (cnt_next_last)
  );

  always_comb begin
    state_d       = state_q;
    cnt_load      = 1'b0;
    cnt_addr_step = 1'b0;
    cnt_rem_step  = 1'b0;
    enable        = 1'b0;
    write         = 1'b0;
    read          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_load = 1'b1;
          state_d  = (cmd_write == CMD_WRITE) ? ST_WRITE : ST_RD_FIRST;
        end
      end
      ST_WRITE: begin
        if (wr_valid) begin
          enable        = 1'b1;
          write         = 1'b1;
          cnt_addr_step = 1'b1;
          cnt_rem_step  = 1'b1;
          if (cnt_last) state_d = ST_IDLE;
        end
      end
      // Prime the RAM's read latch; data first appears on the bus next cycle.
      ST_RD_FIRST: begin
        enable        = 1'b1;
        cnt_addr_step = 1'b1;
        state_d       = cnt_last ? ST_RD_LAST : ST_RD_STREAM;
      end
      ST_RD_STREAM: begin
        enable        = 1'b1;
        read          = 1'b1;
        cnt_addr_step = 1'b1;
        cnt_rem_step  = 1'b1;
        if (cnt_next_last) state_d = ST_RD_LAST;
      end
      ST_RD_LAST: begin
        read    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign capture     = (state_q == ST_RD_STREAM) || (state_q == ST_RD_LAST);
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign wr_ready    = (state_q == ST_WRITE);
  assign address_bus = (state_q == ST_IDLE) ? '0 : cnt_addr;
  assign data_bus    = write ? wr_data : {DATA_WIDTH{1'bz}};
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= capture;
      if (capture) rd_data_q <= data_bus;
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: a behavioural block-RAM responder on the shared bus plus a
// command-level memory model that every read-back is checked against.
module tb_ram_bus_master;

  localparam int AW = 11;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic [AW-1:0] address_bus;
  wire  [DW-1:0] data_bus;
  logic          enable;
  logic          write;
  logic          read;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_bus_master dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .address_bus (address_bus),
    .data_bus    (data_bus),
    .enable      (enable),
    .write       (write),
    .read        (read)
  );

  // RAM responder: stores on enable&write, latches the read word on enable&!write,
  // and drives that latched word while read is high.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_dout = '0;
  int            ram_wr_cnt = 0;
  logic [AW-1:0] wr_log[$];
  int            rw_overlap = 0;

  always @(posedge clk) begin
    if (enable && write) begin
      mem[address_bus] <= data_bus;
      ram_wr_cnt <= ram_wr_cnt + 1;
      wr_log.push_back(address_bus);
    end
    if (enable && !write) ram_dout <= mem[address_bus];
  end
  assign data_bus = read ? ram_dout : {DW{1'bz}};

  always @(negedge clk) if (read && write) rw_overlap <= rw_overlap + 1;

  // Command-level memory model.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            ref_vld [0:(1<<AW)-1];

  task automatic do_write(input logic [AW-1:0] a, input int len, input logic [DW-1:0] wd[$],
                          input bit stall, output int bad);
    int i = 0;
    int guard = 0;
    bit tog = 1'b0;
    logic [AW-1:0] ai;
    bad = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = LW'(len);
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) bad += 1000;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (i <= len && guard < 300) begin
      wr_valid = stall ? tog : 1'b1;
      tog = !tog;
      if (wr_valid) wr_data = wd[i];
      else wr_data = DW'($urandom);
      #1;
      if (enable !== wr_valid || write !== wr_valid || wr_ready !== 1'b1) bad++;
      if (wr_valid) i++;
      @(negedge clk);
      guard++;
    end
    wr_valid = 1'b0;
    if (i <= len) bad += 1000;
    for (int k = 0; k <= len; k++) begin
      ai = a + AW'(k);
      ref_mem[ai] = wd[k];
      ref_vld[ai] = 1'b1;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int len, output logic [DW-1:0] rq[$],
                         output int first_c, output int last_c, output int busy_c, output int ready_c);
    int guard = 0;
    rq = {};
    first_c = -1; last_c = -1; busy_c = 0; ready_c = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = LW'(len);
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c < len + 8; c++) begin
      wr_data = DW'($urandom);
      #1;
      if (busy) busy_c++;
      if (cmd_ready && ready_c < 0) ready_c = c;
      if (rd_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        rq.push_back(rd_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, wr_ready, rd_valid, busy, enable, write, read} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 1000000", {cmd_ready, wr_ready, rd_valid, busy, enable, write, read});
    end
    n_cmp++;
    if (address_bus !== '0) begin n_err++; $display("FAIL reset_addr: got %0h expected 0", address_bus); end
    n_cmp++;
    if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [DW-1:0] wd[$];
    logic [DW-1:0] rq[$];
    int bad, fc, lc, bc, rc;
    wd.push_back(16'hBEEF);
    do_write(11'h010, 0, wd, 1'b0, bad);
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL single_wr_strobes: got %0d bad expected 0", bad); end
    do_read(11'h010, 0, rq, fc, lc, bc, rc);
    n_cmp++;
    if (rq.size() !== 1 || rq[0] !== 16'hBEEF) begin
      n_err++; $display("FAIL single_rd_data: got %0d words first %0h expected 1 word beef", rq.size(), rq.size() > 0 ? rq[0] : 16'h0);
    end
    n_cmp++;
    if (fc !== 3) begin n_err++; $display("FAIL single_rd_latency: got cycle %0d expected 3", fc); end
    n_cmp++;
    if (bc !== 2 || rc !== 3) begin n_err++; $display("FAIL single_rd_busy: got busy %0d ready@%0d expected 2 and 3", bc, rc); end
  endtask

  task automatic test_burst();
    logic [DW-1:0] wd[$];
    logic [DW-1:0] rq[$];
    int bad, fc, lc, bc, rc, ov0;
    ov0 = rw_overlap;
    for (int i = 0; i < 8; i++) wd.push_back(DW'(16'h1000 + i));
    do_write(11'h100, 7, wd, 1'b0, bad);
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL burst_wr_strobes: got %0d bad expected 0", bad); end
    do_read(11'h100, 7, rq, fc, lc, bc, rc);
    n_cmp++;
    if (rq.size() !== 8 || fc !== 3 || lc !== 10) begin
      n_err++; $display("FAIL burst_rd_timing: got %0d words cycles %0d..%0d expected 8 words 3..10", rq.size(), fc, lc);
    end
    for (int i = 0; i < rq.size(); i++) begin
      n_cmp++;
      if (rq[i] !== DW'(16'h1000 + i)) begin
        n_err++; $display("FAIL burst_rd_word%0d: got %0h expected %0h", i, rq[i], 16'h1000 + i);
      end
    end
    n_cmp++;
    if (bc !== 9 || rc !== 10) begin n_err++; $display("FAIL burst_rd_busy: got busy %0d ready@%0d expected 9 and 10", bc, rc); end
    n_cmp++;
    if (rw_overlap !== ov0) begin n_err++; $display("FAIL burst_rw_overlap: got %0d expected %0d", rw_overlap, ov0); end
  endtask

  task automatic test_write_stall();
    logic [DW-1:0] wd[$];
    int bad;
    wr_log = {};
    for (int i = 0; i < 4; i++) wd.push_back(DW'($urandom));
    do_write(11'h200, 3, wd, 1'b1, bad);
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL stall_strobes: got %0d bad cycles expected 0", bad); end
    n_cmp++;
    if (wr_log.size() !== 4) begin n_err++; $display("FAIL stall_wr_count: got %0d expected 4", wr_log.size()); end
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      n_cmp++;
      if (wr_log[i] !== AW'(11'h200 + i) || mem[AW'(11'h200 + i)] !== wd[i]) begin
        n_err++; $display("FAIL stall_wr%0d: got addr %0h data %0h expected addr %0h data %0h",
                          i, wr_log[i], mem[AW'(11'h200 + i)], 11'h200 + i, wd[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] wd[$];
    logic [DW-1:0] rq[$];
    logic [AW-1:0] exp_a[3];
    int bad, fc, lc, bc, rc;
    exp_a[0] = 11'h7FF; exp_a[1] = 11'h000; exp_a[2] = 11'h001;
    wr_log = {};
    for (int i = 0; i < 3; i++) wd.push_back(DW'($urandom));
    do_write(11'h7FF, 2, wd, 1'b0, bad);
    n_cmp++;
    if (wr_log.size() !== 3) begin n_err++; $display("FAIL wrap_wr_count: got %0d expected 3", wr_log.size()); end
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      n_cmp++;
      if (wr_log[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr%0d: got %0h expected %0h", i, wr_log[i], exp_a[i]); end
    end
    do_read(11'h7FF, 2, rq, fc, lc, bc, rc);
    n_cmp++;
    if (rq.size() !== 3) begin n_err++; $display("FAIL wrap_rd_count: got %0d expected 3", rq.size()); end
    for (int i = 0; i < rq.size(); i++) begin
      n_cmp++;
      if (rq[i] !== ref_mem[exp_a[i]]) begin n_err++; $display("FAIL wrap_rd%0d: got %0h expected %0h", i, rq[i], ref_mem[exp_a[i]]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] wd[$];
    logic [DW-1:0] rq[$];
    logic [AW-1:0] ai;
    int bad, nw, c, wr_base, fc, lc, bc, rc;
    nw = 0; c = 0;
    for (int i = 0; i < 8; i++) wd.push_back(DW'($urandom));
    do_write(11'h300, 7, wd, 1'b0, bad);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 11'h300; cmd_len = 8'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (nw < 3 && c < 20) begin
      if (rd_valid) begin
        ai = 11'h300 + AW'(nw);
        n_cmp++;
        if (rd_data !== ref_mem[ai]) begin n_err++; $display("FAIL rstmid_word%0d: got %0h expected %0h", nw, rd_data, ref_mem[ai]); end
        nw++;
      end
      if (nw < 3) begin @(negedge clk); c++; end
    end
    n_cmp++;
    if (nw !== 3) begin n_err++; $display("FAIL rstmid_words_seen: got %0d expected 3", nw); end
    reset_n = 1'b0;
    wr_base = ram_wr_cnt;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, wr_ready, rd_valid, busy, enable, write, read} !== 7'b1000000 || address_bus !== '0) begin
      n_err++; $display("FAIL rstmid_idle: got %b addr %0h expected 1000000 addr 0",
                        {cmd_ready, wr_ready, rd_valid, busy, enable, write, read}, address_bus);
    end
    reset_n = 1'b1;
    n_cmp++;
    if (ram_wr_cnt !== wr_base) begin n_err++; $display("FAIL rstmid_no_writes: got %0d expected %0d", ram_wr_cnt, wr_base); end
    do_read(11'h301, 2, rq, fc, lc, bc, rc);
    n_cmp++;
    if (rq.size() !== 3 || fc !== 3) begin n_err++; $display("FAIL rstmid_fresh_timing: got %0d words first %0d expected 3 words first 3", rq.size(), fc); end
    for (int i = 0; i < rq.size(); i++) begin
      ai = 11'h301 + AW'(i);
      n_cmp++;
      if (rq[i] !== ref_mem[ai]) begin n_err++; $display("FAIL rstmid_fresh%0d: got %0h expected %0h", i, rq[i], ref_mem[ai]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] wd[2];
    logic [DW-1:0] got[$];
    logic [AW-1:0] a;
    int nacc, wi, gap, ov0;
    nacc = 0; wi = 0; gap = 0;
    a = AW'($urandom);
    wd[0] = DW'($urandom); wd[1] = DW'($urandom);
    ov0 = rw_overlap;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (rd_valid) got.push_back(rd_data);
      if (cmd_ready && nacc == 1) gap++;
      cmd_valid = (nacc < 2); cmd_write = (nacc == 0); cmd_addr = a; cmd_len = 8'd1;
      wr_valid = wr_ready && (wi < 2);
      if (wi < 2) wr_data = wd[wi];
      else wr_data = DW'($urandom);
      if (cmd_ready && cmd_valid) nacc++;
      if (wr_valid && wr_ready) wi++;
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;
    ref_mem[a] = wd[0]; ref_vld[a] = 1'b1;
    ref_mem[a + AW'(1)] = wd[1]; ref_vld[a + AW'(1)] = 1'b1;
    n_cmp++;
    if (gap !== 1) begin n_err++; $display("FAIL b2b_turnaround: got %0d idle cycles expected 1", gap); end
    n_cmp++;
    if (got.size() !== 2) begin n_err++; $display("FAIL b2b_rd_count: got %0d expected 2", got.size()); end
    for (int i = 0; i < got.size() && i < 2; i++) begin
      n_cmp++;
      if (got[i] !== wd[i]) begin n_err++; $display("FAIL b2b_rd%0d: got %0h expected %0h", i, got[i], wd[i]); end
    end
    n_cmp++;
    if (rw_overlap !== ov0) begin n_err++; $display("FAIL b2b_rw_overlap: got %0d expected %0d", rw_overlap, ov0); end
  endtask

  task automatic test_random();
    logic [AW-1:0] ra[6];
    int rl[6];
    logic [DW-1:0] wd[$];
    logic [DW-1:0] rq[$];
    logic [AW-1:0] a, ai;
    int bad, off, l, fc, lc, bc, rc;
    for (int n = 0; n < 6; n++) begin
      wd = {};
      ra[n] = AW'($urandom);
      rl[n] = $urandom_range(0, 15);
      for (int i = 0; i <= rl[n]; i++) wd.push_back(DW'($urandom));
      do_write(ra[n], rl[n], wd, 1'($urandom_range(0, 1)), bad);
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL rand_wr%0d: got %0d bad expected 0", n, bad); end
    end
    for (int n = 0; n < 6; n++) begin
      off = $urandom_range(0, rl[n]);
      l = $urandom_range(0, rl[n] - off);
      a = ra[n] + AW'(off);
      do_read(a, l, rq, fc, lc, bc, rc);
      n_cmp++;
      if (rq.size() !== l + 1 || fc !== 3 || lc !== 3 + l) begin
        n_err++; $display("FAIL rand_rd%0d_timing: got %0d words %0d..%0d expected %0d words 3..%0d", n, rq.size(), fc, lc, l + 1, 3 + l);
      end
      for (int i = 0; i < rq.size(); i++) begin
        ai = a + AW'(i);
        if (ref_vld[ai]) begin
          n_cmp++;
          if (rq[i] !== ref_mem[ai]) begin n_err++; $display("FAIL rand_rd%0d_word%0d: got %0h expected %0h", n, i, rq[i], ref_mem[ai]); end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_write_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
